// File: rtl/ebi_rx_deframer.sv
// rtl/ebi_rx_deframer.sv - receive-side deframer for one off-die EBI lane
//
// Rebuilds one channel message from framed wire beats:
//   start (bit0=1), id {vc,ch}, data beats with a parity beat after every
//   PARITY_LENGTH data beats (and after the last data beat), end (bit0=1).
// A clean frame is offered to the VC buffer and acknowledged with a SUCCESS
// credit on the handshake cycle; a parity or framing error discards the
// message and issues a FAILURE credit instead.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   phy_vld_i     wire beat valid (low cycles are ignored)
//   phy_data_i    wire beat payload
//   msg_vld_o     rebuilt message valid, held until msg_rdy_i
//   msg_rdy_i     VC buffer accepts message
//   msg_o         rebuilt message
//   ch_id_o       channel id
//   vc_id_o       virtual channel id
//   credit_vld_o  one-cycle credit strobe
//   credit_o      0 = none, 1 = SUCCESS, 2 = FAILURE
//   proto_err_o   one-cycle pulse: beat arrived while a credit was pending

module ebi_rx_deframer #(
`ifdef SYNTHESIS
    parameter int OFF_DIE_WD    = 1,
`else
    parameter int OFF_DIE_WD    = 32,
`endif
    parameter int MSG_LEN       = 80,
    parameter int PARITY_LENGTH = 8,
    parameter int VC_W          = 2,
    parameter int CH_W          = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  phy_vld_i,
    input  logic [OFF_DIE_WD-1:0] phy_data_i,
    output logic                  msg_vld_o,
    input  logic                  msg_rdy_i,
    output logic [MSG_LEN-1:0]    msg_o,
    output logic [CH_W-1:0]       ch_id_o,
    output logic [VC_W-1:0]       vc_id_o,
    output logic                  credit_vld_o,
    output logic [1:0]            credit_o,
    output logic                  proto_err_o
);

    localparam int NB   = (MSG_LEN + OFF_DIE_WD - 1) / OFF_DIE_WD;
    localparam int BC_W = $clog2(NB + 1);
    localparam int GC_W = $clog2(PARITY_LENGTH + 1);

    localparam logic [1:0] CREDIT_NONE    = 2'd0;
    localparam logic [1:0] CREDIT_SUCCESS = 2'd1;
    localparam logic [1:0] CREDIT_FAILURE = 2'd2;

    typedef enum logic [1:0] {
        RECV_IDLE     = 2'd0,
        GET_VC_NUM    = 2'd1,
        RECV_MESSSAGE = 2'd2,
        MAKE_CREDIT   = 2'd3
    } recv_state_t;

    recv_state_t               state_q, state_d;
    logic [MSG_LEN-1:0]        msg_q;
    logic [CH_W-1:0]           ch_q;
    logic [VC_W-1:0]           vc_q;
    logic [BC_W-1:0]           beat_cnt;
    logic [GC_W-1:0]           grp_cnt;
    logic [OFF_DIE_WD-1:0]     acc_q;
    logic                      err_q;
    logic                      msg_vld_q;
    logic                      proto_err_q;
    logic [CH_W+VC_W-1:0]      id_bits;

    // Sub-phase inside RECV_MESSSAGE is implied by the counters: a parity beat
    // is due once a group is full or once all data beats are in with a
    // non-empty group; with all data in and the group flushed, the end beat.
    logic last_data_done;
    logic in_parity;
    logic in_end;

    assign last_data_done = (beat_cnt == BC_W'(NB));
    assign in_parity      = (grp_cnt == GC_W'(PARITY_LENGTH)) ||
                            (last_data_done && (grp_cnt != '0));
    assign in_end         = last_data_done && (grp_cnt == '0);

    always_comb begin
        id_bits = '0;
        for (int i = 0; i < CH_W + VC_W; i++) begin
            if (i < OFF_DIE_WD) id_bits[i] = phy_data_i[i];
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RECV_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            RECV_IDLE:     if (phy_vld_i && phy_data_i[0]) state_d = GET_VC_NUM;
            GET_VC_NUM:    if (phy_vld_i) state_d = RECV_MESSSAGE;
            RECV_MESSSAGE: if (phy_vld_i && in_end) state_d = MAKE_CREDIT;
            MAKE_CREDIT:   if (err_q || msg_rdy_i) state_d = RECV_IDLE;
            default:       state_d = RECV_IDLE;
        endcase
    end

    // Output logic: the credit strobe coincides with the message handshake
    // (or fires immediately when the frame was bad).
    always_comb begin
        credit_vld_o = 1'b0;
        credit_o     = CREDIT_NONE;
        if (state_q == MAKE_CREDIT) begin
            if (err_q) begin
                credit_vld_o = 1'b1;
                credit_o     = CREDIT_FAILURE;
            end else if (msg_rdy_i) begin
                credit_vld_o = 1'b1;
                credit_o     = CREDIT_SUCCESS;
            end
        end
    end

    // Datapath: message assembly, parity accumulation, error tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_q       <= '0;
            ch_q        <= '0;
            vc_q        <= '0;
            beat_cnt    <= '0;
            grp_cnt     <= '0;
            acc_q       <= '0;
            err_q       <= 1'b0;
            msg_vld_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            proto_err_q <= (state_q == MAKE_CREDIT) && phy_vld_i;
            if (msg_vld_q && msg_rdy_i) msg_vld_q <= 1'b0;

            if (phy_vld_i) begin
                case (state_q)
                    RECV_IDLE: begin
                        if (phy_data_i[0]) err_q <= 1'b0;
                    end
                    GET_VC_NUM: begin
                        ch_q     <= id_bits[CH_W-1:0];
                        vc_q     <= id_bits[CH_W+VC_W-1:CH_W];
                        beat_cnt <= '0;
                        grp_cnt  <= '0;
                        acc_q    <= '0;
                        err_q    <= 1'b0;
                    end
                    RECV_MESSSAGE: begin
                        if (in_end) begin
                            err_q     <= err_q | ~phy_data_i[0];
                            msg_vld_q <= ~err_q & phy_data_i[0];
                        end else if (in_parity) begin
                            if (phy_data_i != acc_q) err_q <= 1'b1;
                            acc_q   <= '0;
                            grp_cnt <= '0;
                        end else begin
                            // Bits of the last beat beyond MSG_LEN are dropped.
                            for (int j = 0; j < MSG_LEN; j++) begin
                                if ((j / OFF_DIE_WD) == int'(beat_cnt))
                                    msg_q[j] <= phy_data_i[j % OFF_DIE_WD];
                            end
                            acc_q    <= acc_q ^ phy_data_i;
                            grp_cnt  <= grp_cnt + GC_W'(1);
                            beat_cnt <= beat_cnt + BC_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign msg_vld_o   = msg_vld_q;
    assign msg_o       = msg_q;
    assign ch_id_o     = ch_q;
    assign vc_id_o     = vc_q;
    assign proto_err_o = proto_err_q;

endmodule
